// File: rtl/clock_control_logic_in_if.sv
// Enable request / acknowledge handshake between the controlling domain and
// the clock-gate sequencer.
interface clock_control_logic_in_if;
  logic async_enable;
  logic async_enable_ack;

  modport master (output async_enable, input  async_enable_ack);
  modport slave  (input  async_enable, output async_enable_ack);
endinterface

// File: rtl/clock_control_logic_in.sv
// Clock-gate start/stop sequencer: synchronizes an asynchronous enable request
// and walks the gate through timed STARTING/STOPPING phases with a four-phase ack.
//
// state    | meaning
// OFF      | gate disabled, ack low, waiting for enable
// STARTING | gate enabled, counting START_DELAY before ack rises
// ON       | gate enabled, ack high
// STOPPING | gate disabled, counting STOP_DELAY before ack falls
module clock_control_logic_in #(
  parameter int START_DELAY = 4,
  parameter int STOP_DELAY  = 2
) (
  input  logic                            clock,
  input  logic                            resetn,
  clock_control_logic_in_if.slave         hs,
  output logic                            gate_enable,
  output logic                            clock_running,
  output logic                            busy,
  output logic                            start_aborted
);

  typedef enum logic [1:0] {
    S_OFF      = 2'd0,
    S_STARTING = 2'd1,
    S_ON       = 2'd2,
    S_STOPPING = 2'd3
  } state_t;

  localparam logic [7:0] START_LOAD = 8'(START_DELAY - 1);
  localparam logic [7:0] STOP_LOAD  = 8'(STOP_DELAY - 1);

  logic       sync1_q, sync2_q;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       aborted_q, aborted_d;
  logic       abort_pulse_d;
  logic       gate_q, ack_q, running_q, busy_q, abort_pulse_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    aborted_d     = aborted_q;
    abort_pulse_d = 1'b0;
    case (state_q)
      S_OFF: begin
        cnt_d     = 8'd0;
        aborted_d = 1'b0;
        if (sync2_q) begin
          state_d = S_STARTING;
          cnt_d   = START_LOAD;
        end
      end
      S_STARTING: begin
        if (!sync2_q) begin
          state_d       = S_STOPPING;
          cnt_d         = STOP_LOAD;
          aborted_d     = 1'b1;
          abort_pulse_d = 1'b1;
        end else if (cnt_q == 8'd0) begin
          state_d = S_ON;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ON: begin
        cnt_d     = 8'd0;
        aborted_d = 1'b0;
        if (!sync2_q) begin
          state_d = S_STOPPING;
          cnt_d   = STOP_LOAD;
        end
      end
      S_STOPPING: begin
        // A renewed request here is ignored; the stop always runs to OFF.
        if (cnt_q == 8'd0) begin
          state_d   = S_OFF;
          aborted_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d   = S_OFF;
        cnt_d     = 8'd0;
        aborted_d = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      state_q       <= S_OFF;
      cnt_q         <= 8'd0;
      aborted_q     <= 1'b0;
      gate_q        <= 1'b0;
      ack_q         <= 1'b0;
      running_q     <= 1'b0;
      busy_q        <= 1'b0;
      abort_pulse_q <= 1'b0;
    end else begin
      sync1_q       <= hs.async_enable;
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      aborted_q     <= aborted_d;
      gate_q        <= (state_d == S_STARTING) || (state_d == S_ON);
      ack_q         <= (state_d == S_ON) || ((state_d == S_STOPPING) && !aborted_d);
      running_q     <= (state_d == S_ON);
      busy_q        <= (state_d == S_STARTING) || (state_d == S_STOPPING);
      abort_pulse_q <= abort_pulse_d;
    end
  end

  assign hs.async_enable_ack = ack_q;
  assign gate_enable         = gate_q;
  assign clock_running       = running_q;
  assign busy                = busy_q;
  assign start_aborted       = abort_pulse_q;

endmodule

// File: tb/tb_clock_control_logic_in.sv
// Directed and randomized checks of the clock-gate sequencer with
// START_DELAY=4, STOP_DELAY=2.
module tb_clock_control_logic_in;

  localparam int START_DELAY = 4;
  localparam int STOP_DELAY  = 2;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic gate_enable, clock_running, busy, start_aborted;

  int n_cmp = 0;
  int n_bad = 0;

  clock_control_logic_in_if hs ();

  clock_control_logic_in #(
    .START_DELAY (START_DELAY),
    .STOP_DELAY  (STOP_DELAY)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .hs            (hs.slave),
    .gate_enable   (gate_enable),
    .clock_running (clock_running),
    .busy          (busy),
    .start_aborted (start_aborted)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    int gate_hi_run;
    int gate_lo_run;
    int hold;
    logic prev_ack;
    logic prev_abort;

    hs.async_enable = 1'b0;
    resetn = 1'b0;
    tick();
    tick();
    chk("rst_gate", gate_enable, 1'b0);
    chk("rst_ack", hs.async_enable_ack, 1'b0);
    chk("rst_running", clock_running, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_aborted", start_aborted, 1'b0);
    resetn = 1'b1;
    tick();
    tick();

    // Start: request sampled at e0, gate at e2, ack at e6.
    hs.async_enable = 1'b1;
    tick();
    chk("start_e0_gate", gate_enable, 1'b0);
    tick();
    chk("start_e1_gate", gate_enable, 1'b0);
    tick();
    chk("start_e2_gate", gate_enable, 1'b1);
    chk("start_e2_busy", busy, 1'b1);
    chk("start_e2_ack", hs.async_enable_ack, 1'b0);
    tick();
    tick();
    tick();
    chk("start_e5_ack", hs.async_enable_ack, 1'b0);
    chk("start_e5_running", clock_running, 1'b0);
    tick();
    chk("start_e6_ack", hs.async_enable_ack, 1'b1);
    chk("start_e6_running", clock_running, 1'b1);
    chk("start_e6_busy", busy, 1'b0);

    // Stop: gate drops at e2, ack at e4.
    hs.async_enable = 1'b0;
    tick();
    tick();
    chk("stop_e1_gate", gate_enable, 1'b1);
    tick();
    chk("stop_e2_gate", gate_enable, 1'b0);
    chk("stop_e2_ack", hs.async_enable_ack, 1'b1);
    chk("stop_e2_busy", busy, 1'b1);
    chk("stop_e2_running", clock_running, 1'b0);
    tick();
    chk("stop_e3_ack", hs.async_enable_ack, 1'b1);
    tick();
    chk("stop_e4_ack", hs.async_enable_ack, 1'b0);
    chk("stop_e4_busy", busy, 1'b0);
    tick();
    tick();

    // Abort: request high for 3 sampled edges (e0..e2).
    hs.async_enable = 1'b1;
    tick();
    tick();
    tick();
    hs.async_enable = 1'b0;
    chk("abort_e2_gate", gate_enable, 1'b1);
    tick();
    chk("abort_e3_gate", gate_enable, 1'b1);
    tick();
    chk("abort_e4_gate", gate_enable, 1'b1);
    chk("abort_e4_ack", hs.async_enable_ack, 1'b0);
    chk("abort_e4_pulse", start_aborted, 1'b0);
    tick();
    chk("abort_e5_gate", gate_enable, 1'b0);
    chk("abort_e5_pulse", start_aborted, 1'b1);
    chk("abort_e5_ack", hs.async_enable_ack, 1'b0);
    chk("abort_e5_busy", busy, 1'b1);
    tick();
    chk("abort_e6_pulse", start_aborted, 1'b0);
    chk("abort_e6_ack", hs.async_enable_ack, 1'b0);
    chk("abort_e6_busy", busy, 1'b1);
    tick();
    chk("abort_e7_busy", busy, 1'b0);
    chk("abort_e7_gate", gate_enable, 1'b0);
    tick();
    tick();

    // Re-request during STOPPING.
    hs.async_enable = 1'b1;
    repeat (7) tick();
    chk("rereq_on_running", clock_running, 1'b1);
    hs.async_enable = 1'b0;
    tick();
    hs.async_enable = 1'b1;
    tick();
    tick();
    chk("rereq_e2_gate", gate_enable, 1'b0);
    chk("rereq_e2_ack", hs.async_enable_ack, 1'b1);
    tick();
    chk("rereq_e3_gate", gate_enable, 1'b0);
    chk("rereq_e3_busy", busy, 1'b1);
    tick();
    chk("rereq_e4_ack", hs.async_enable_ack, 1'b0);
    chk("rereq_e4_gate", gate_enable, 1'b0);
    chk("rereq_e4_busy", busy, 1'b0);
    tick();
    chk("rereq_e5_gate", gate_enable, 1'b1);
    chk("rereq_e5_busy", busy, 1'b1);
    tick();
    tick();
    tick();
    chk("rereq_e8_ack", hs.async_enable_ack, 1'b0);
    tick();
    chk("rereq_e9_ack", hs.async_enable_ack, 1'b1);

    // Reset mid-ON with request held: outputs clear at the reset edge,
    // gate returns on the third edge counted from the reset edge.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rston_gate", gate_enable, 1'b0);
    chk("rston_ack", hs.async_enable_ack, 1'b0);
    chk("rston_running", clock_running, 1'b0);
    chk("rston_busy", busy, 1'b0);
    tick();
    chk("rston_r1_gate", gate_enable, 1'b0);
    tick();
    chk("rston_r2_gate", gate_enable, 1'b0);
    tick();
    chk("rston_r3_gate", gate_enable, 1'b1);
    tick();
    tick();
    tick();
    chk("rston_r6_ack", hs.async_enable_ack, 1'b0);
    tick();
    chk("rston_r7_ack", hs.async_enable_ack, 1'b1);

    // Random toggling with random phase; four-phase timing checker.
    gate_hi_run = 4;
    gate_lo_run = 0;
    prev_ack    = hs.async_enable_ack;
    prev_abort  = 1'b0;
    hold        = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      n_cmp++;
      assert (!$isunknown({gate_enable, hs.async_enable_ack, clock_running, busy, start_aborted})) else begin
        n_bad++;
        $error("FAIL rand_x: observed %b expected no X at cycle %0d",
               {gate_enable, hs.async_enable_ack, clock_running, busy, start_aborted}, i);
      end
      if (hs.async_enable_ack && !prev_ack) begin
        n_cmp++;
        assert (gate_enable && gate_hi_run >= START_DELAY) else begin
          n_bad++;
          $error("FAIL rand_ack_rise: observed gate run %0d expected >= %0d at cycle %0d",
                 gate_hi_run, START_DELAY, i);
        end
      end
      if (!hs.async_enable_ack && prev_ack) begin
        n_cmp++;
        assert (!gate_enable && gate_lo_run >= STOP_DELAY) else begin
          n_bad++;
          $error("FAIL rand_ack_fall: observed gate-low run %0d expected >= %0d at cycle %0d",
                 gate_lo_run, STOP_DELAY, i);
        end
      end
      if (start_aborted) begin
        n_cmp++;
        assert (!prev_abort && !hs.async_enable_ack) else begin
          n_bad++;
          $error("FAIL rand_abort: observed prev_pulse %b ack %b expected 0 0 at cycle %0d",
                 prev_abort, hs.async_enable_ack, i);
        end
      end
      gate_hi_run = gate_enable ? gate_hi_run + 1 : 0;
      gate_lo_run = gate_enable ? 0 : gate_lo_run + 1;
      prev_ack    = hs.async_enable_ack;
      prev_abort  = start_aborted;
      if (hold == 0) begin
        #($urandom_range(1, 8));
        hs.async_enable = ~hs.async_enable;
        hold = $urandom_range(1, 12);
      end else begin
        hold--;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
